x_pattern_gen: RTL and testbench

Single-clock AXI4-Stream frame source that produces the 64-bit pixel stream consumed by `x_chopper` and the other line-processing blocks. It emits a programmable number of rows of a deterministic byte pattern and carries the codebase sync convention on `tuser` (SOF/EOF/SOL/EOL) with `tlast` on every row end. It is the upstream transmitter used for built-in self-test and for the validation benches of downstream stream consumers.

---
 rtl/x_pattern_gen_if.sv | 11 +
 rtl/x_pattern_gen.sv | 166 ++++++++++++++++
 tb/tb_x_pattern_gen.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/x_pattern_gen_if.sv
// AXI4-Stream pixel bus carried between x_pattern_gen and downstream line processors.
interface x_pattern_gen_if;
    logic        tvalid;
    logic        tready;
    logic [63:0] tdata;
    logic [3:0]  tuser;
    logic        tlast;

    modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tuser, input tlast, output tready);
endinterface

// File: rtl/x_pattern_gen.sv
// AXI4-Stream frame source: programmable rows of a byte ramp with SOF/EOF/SOL/EOL on tuser.
// Every output is a flop loaded from the next-state view of the counters.
module x_pattern_gen (
    input  logic            aclk,
    input  logic            aclk_reset,
    input  logic            aclk_start,
    input  logic [15:0]     aclk_x_size,
    input  logic [15:0]     aclk_y_size,
    input  logic [15:0]     aclk_gap,
    input  logic            aclk_pattern,
    output logic            aclk_busy,
    output logic            aclk_frame_done,
    x_pattern_gen_if.master axis
);
    typedef enum logic [1:0] {IDLE, LINE, GAP} state_t;

    state_t      state_q, state_d;
    logic [15:0] beats_q, beats_d;
    logic [15:0] rows_q, rows_d;
    logic [15:0] gap_q, gap_d;
    logic        pattern_q, pattern_d;
    logic [15:0] beat_q, beat_d;
    logic [15:0] row_q, row_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic        tvalid_q, tvalid_d;
    logic [63:0] tdata_q, tdata_d;
    logic [3:0]  tuser_q, tuser_d;
    logic        tlast_q, tlast_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;

    logic        xfer;
    logic        last_beat;
    logic        last_row;
    logic        nxt_first;
    logic        nxt_last;
    logic        nxt_last_row;
    logic [7:0]  row_off;
    logic [15:0] start_beats;

    assign xfer        = tvalid_q && axis.tready;
    assign last_beat   = (beat_q == beats_q - 16'd1);
    assign last_row    = (row_q == rows_q - 16'd1);
    assign start_beats = aclk_x_size >> 3;

    always_comb begin
        state_d      = state_q;
        beats_d      = beats_q;
        rows_d       = rows_q;
        gap_d        = gap_q;
        pattern_d    = pattern_q;
        beat_d       = beat_q;
        row_d        = row_q;
        gap_cnt_d    = gap_cnt_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (aclk_start) begin
                    beats_d   = start_beats;
                    rows_d    = aclk_y_size;
                    gap_d     = aclk_gap;
                    pattern_d = aclk_pattern;
                    beat_d    = 16'd0;
                    row_d     = 16'd0;
                    if (start_beats == 16'd0 || aclk_y_size == 16'd0) begin
                        frame_done_d = 1'b1;
                    end else begin
                        // One pass through GAP delays the first beat by a cycle after start.
                        state_d   = GAP;
                        gap_cnt_d = 16'd0;
                    end
                end
            end
            LINE: begin
                if (xfer) begin
                    if (last_beat) begin
                        beat_d = 16'd0;
                        if (last_row) begin
                            state_d      = IDLE;
                            frame_done_d = 1'b1;
                        end else begin
                            row_d = row_q + 16'd1;
                            if (gap_q != 16'd0) begin
                                state_d   = GAP;
                                gap_cnt_d = gap_q - 16'd1;
                            end
                        end
                    end else begin
                        beat_d = beat_q + 16'd1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == 16'd0) begin
                    state_d = LINE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        tvalid_d     = (state_d == LINE);
        tdata_d      = 64'd0;
        tuser_d      = 4'd0;
        tlast_d      = 1'b0;
        nxt_first    = (beat_d == 16'd0);
        nxt_last     = (beat_d == beats_d - 16'd1);
        nxt_last_row = (row_d == rows_d - 16'd1);
        row_off      = pattern_d ? row_d[7:0] : 8'h00;
        if (tvalid_d) begin
            // Only beat[4:0] matters: 32 beats of 8 bytes cover one full byte wrap.
            for (int b = 0; b < 8; b++) begin
                tdata_d[8*b +: 8] = {beat_d[4:0], 3'b000} + 8'(b) + row_off;
            end
            tuser_d[0] = nxt_first && (row_d == 16'd0);
            tuser_d[2] = nxt_first && (row_d != 16'd0);
            tuser_d[1] = nxt_last && nxt_last_row;
            tuser_d[3] = nxt_last && !nxt_last_row;
            tlast_d    = nxt_last;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge aclk) begin
        if (aclk_reset) begin
            state_q      <= IDLE;
            beats_q      <= 16'd0;
            rows_q       <= 16'd0;
            gap_q        <= 16'd0;
            pattern_q    <= 1'b0;
            beat_q       <= 16'd0;
            row_q        <= 16'd0;
            gap_cnt_q    <= 16'd0;
            tvalid_q     <= 1'b0;
            tdata_q      <= 64'd0;
            tuser_q      <= 4'd0;
            tlast_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beats_q      <= beats_d;
            rows_q       <= rows_d;
            gap_q        <= gap_d;
            pattern_q    <= pattern_d;
            beat_q       <= beat_d;
            row_q        <= row_d;
            gap_cnt_q    <= gap_cnt_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            tuser_q      <= tuser_d;
            tlast_q      <= tlast_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign axis.tvalid     = tvalid_q;
    assign axis.tdata      = tdata_q;
    assign axis.tuser      = tuser_q;
    assign axis.tlast      = tlast_q;
    assign aclk_busy       = busy_q;
    assign aclk_frame_done = frame_done_q;
endmodule

// File: tb/tb_x_pattern_gen.sv
// Directed bench for x_pattern_gen: frame shape, sync flags, gaps, stalls, restart and reset.
module tb_x_pattern_gen;
    logic        aclk = 1'b0;
    logic        aclk_reset;
    logic        aclk_start;
    logic [15:0] aclk_x_size;
    logic [15:0] aclk_y_size;
    logic [15:0] aclk_gap;
    logic        aclk_pattern;
    logic        aclk_busy;
    logic        aclk_frame_done;

    x_pattern_gen_if axis_if ();

    x_pattern_gen dut (
        .aclk            (aclk),
        .aclk_reset      (aclk_reset),
        .aclk_start      (aclk_start),
        .aclk_x_size     (aclk_x_size),
        .aclk_y_size     (aclk_y_size),
        .aclk_gap        (aclk_gap),
        .aclk_pattern    (aclk_pattern),
        .aclk_busy       (aclk_busy),
        .aclk_frame_done (aclk_frame_done),
        .axis            (axis_if)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int passed = 0;

    logic [63:0] cap_data[$];
    logic [3:0]  cap_user[$];
    logic        cap_last[$];
    int          cap_idle[$];
    int          cap_done_pulses;
    int          cap_stall_err;
    int          cap_first_valid;
    int          cap_done_cycle;
    int          cap_last_xfer;
    logic        cap_busy_at1;
    logic        cap_busy_at_done;

    function automatic logic [63:0] exp_data(int n, int r, bit p);
        logic [63:0] d;
        for (int b = 0; b < 8; b++) d[8*b +: 8] = 8'((8*n + b + (p ? r : 0)) % 256);
        return d;
    endfunction

    function automatic logic [3:0] exp_user(int n, int r, int nb, int nr);
        logic [3:0] u;
        u[0] = (n == 0) && (r == 0);
        u[2] = (n == 0) && (r != 0);
        u[1] = (n == nb - 1) && (r == nr - 1);
        u[3] = (n == nb - 1) && (r != nr - 1);
        return u;
    endfunction

    // Number of captured beats that disagree with the reference frame, plus any length error.
    function automatic int stream_errors(int nb, int nr, bit p);
        int errs;
        int total;
        total = nb * nr;
        errs = (cap_data.size() > total) ? cap_data.size() - total : total - cap_data.size();
        for (int i = 0; i < cap_data.size() && i < total; i++) begin
            if (cap_data[i] !== exp_data(i % nb, i / nb, p)) errs++;
            if (cap_user[i] !== exp_user(i % nb, i / nb, nb, nr)) errs++;
            if (cap_last[i] !== ((i % nb) == nb - 1)) errs++;
        end
        return errs;
    endfunction

    task automatic set_cfg(input logic [15:0] x, input logic [15:0] y, input logic [15:0] g, input logic p);
        aclk_x_size  = x;
        aclk_y_size  = y;
        aclk_gap     = g;
        aclk_pattern = p;
    endtask

    // Pulses start at cycle 0, optionally again at restart_cycle, and records every accepted beat.
    task automatic collect_frame(input int max_cycles, input bit rand_ready, input logic [15:0] x_after,
                                 input int restart_cycle, output bit timed_out);
        bit          stalled;
        bit          row_ended;
        int          idle;
        int          post;
        logic [63:0] s_data;
        logic [3:0]  s_user;
        logic        s_last;
        cap_data.delete();
        cap_user.delete();
        cap_last.delete();
        cap_idle.delete();
        cap_done_pulses  = 0;
        cap_stall_err    = 0;
        cap_first_valid  = -1;
        cap_done_cycle   = -1;
        cap_last_xfer    = -1;
        cap_busy_at1     = 1'bx;
        cap_busy_at_done = 1'bx;
        stalled   = 0;
        row_ended = 0;
        idle      = 0;
        post      = 0;
        s_data    = '0;
        s_user    = '0;
        s_last    = 1'b0;
        timed_out = 1;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge aclk);
            if (stalled && (axis_if.tvalid !== 1'b1 || axis_if.tdata !== s_data ||
                            axis_if.tuser !== s_user || axis_if.tlast !== s_last)) cap_stall_err++;
            if (aclk_frame_done === 1'b1) begin
                cap_done_pulses++;
                if (cap_done_cycle < 0) begin
                    cap_done_cycle   = c;
                    cap_busy_at_done = aclk_busy;
                end
            end
            if (c == 1) begin
                cap_busy_at1 = aclk_busy;
                aclk_x_size  = x_after;
            end
            if (axis_if.tvalid === 1'b1 && cap_first_valid < 0) cap_first_valid = c;
            aclk_start     = (c == 0) || (c == restart_cycle);
            axis_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (axis_if.tvalid === 1'b1) begin
                if (axis_if.tready) begin
                    if (row_ended) cap_idle.push_back(idle);
                    cap_data.push_back(axis_if.tdata);
                    cap_user.push_back(axis_if.tuser);
                    cap_last.push_back(axis_if.tlast);
                    row_ended     = axis_if.tlast;
                    idle          = 0;
                    cap_last_xfer = c;
                    stalled       = 0;
                end else begin
                    stalled = 1;
                    s_data  = axis_if.tdata;
                    s_user  = axis_if.tuser;
                    s_last  = axis_if.tlast;
                end
            end else begin
                stalled = 0;
                if (row_ended) idle++;
            end
            if (cap_done_cycle >= 0) begin
                post++;
                if (post > 3) begin
                    timed_out = 0;
                    break;
                end
            end
        end
        aclk_start     = 1'b0;
        axis_if.tready = 1'b1;
    endtask

    task automatic test_reset();
        aclk_reset = 1'b1;
        repeat (2) @(negedge aclk);
        checks++;
        if ({axis_if.tvalid, axis_if.tlast, aclk_busy, aclk_frame_done} !== 4'b0000)
            $display("[TB] FAIL reset_flags: got %b expected 0000", {axis_if.tvalid, axis_if.tlast, aclk_busy, aclk_frame_done});
        else passed++;
        checks++;
        if (axis_if.tdata !== 64'd0) $display("[TB] FAIL reset_tdata: got %h expected 0", axis_if.tdata);
        else passed++;
        checks++;
        if (axis_if.tuser !== 4'd0) $display("[TB] FAIL reset_tuser: got %h expected 0", axis_if.tuser);
        else passed++;
        aclk_reset = 1'b0;
        @(negedge aclk);
    endtask

    task automatic test_basic_frame();
        bit to;
        int errs;
        set_cfg(16'd256, 16'd4, 16'd0, 1'b0);
        collect_frame(400, 1'b0, 16'd256, -1, to);
        errs = stream_errors(32, 4, 1'b0);
        checks++;
        if (to !== 1'b0) $display("[TB] FAIL basic_timeout: frame did not finish within budget");
        else passed++;
        checks++;
        if (cap_data.size() !== 128) $display("[TB] FAIL basic_count: got %0d expected 128", cap_data.size());
        else passed++;
        checks++;
        if (cap_data.size() < 128) $display("[TB] FAIL basic_short: got %0d beats expected 128", cap_data.size());
        else begin
            if (cap_data[0] !== 64'h0706050403020100 || cap_data[31] !== 64'hFFFEFDFCFBFAF9F8 || cap_data[32] !== 64'h0706050403020100)
                $display("[TB] FAIL basic_data: got %h %h %h expected 0706050403020100 fffefdfcfbfaf9f8 0706050403020100",
                         cap_data[0], cap_data[31], cap_data[32]);
            else passed++;
            checks++;
            if ({cap_user[0], cap_user[32], cap_user[31], cap_user[127]} !== 16'h1482)
                $display("[TB] FAIL basic_tuser: got %h expected 1482", {cap_user[0], cap_user[32], cap_user[31], cap_user[127]});
            else passed++;
        end
        checks++;
        if (errs !== 0) $display("[TB] FAIL basic_stream: got %0d errors expected 0", errs);
        else passed++;
        checks++;
        if (cap_idle.size() !== 3 || cap_idle.sum() !== 0)
            $display("[TB] FAIL basic_rowgap: got %0d gaps totalling %0d expected 3 totalling 0", cap_idle.size(), cap_idle.sum());
        else passed++;
        checks++;
        if (cap_first_valid !== 2) $display("[TB] FAIL basic_latency: got cycle %0d expected 2", cap_first_valid);
        else passed++;
        checks++;
        if (cap_busy_at1 !== 1'b1) $display("[TB] FAIL basic_busy: got %b expected 1", cap_busy_at1);
        else passed++;
        checks++;
        if (cap_done_pulses !== 1 || cap_done_cycle !== cap_last_xfer + 1 || cap_busy_at_done !== 1'b0)
            $display("[TB] FAIL basic_done: got pulses=%0d at %0d busy=%b expected 1 at %0d busy=0",
                     cap_done_pulses, cap_done_cycle, cap_busy_at_done, cap_last_xfer + 1);
        else passed++;
    endtask

    task automatic test_random_ready();
        bit to;
        int errs;
        set_cfg(16'd256, 16'd4, 16'd0, 1'b0);
        collect_frame(2000, 1'b1, 16'd256, -1, to);
        errs = stream_errors(32, 4, 1'b0);
        checks++;
        if (to !== 1'b0 || errs !== 0)
            $display("[TB] FAIL random_stream: got timeout=%0d errors=%0d expected 0 0", to, errs);
        else passed++;
        checks++;
        if (cap_stall_err !== 0) $display("[TB] FAIL random_stall: got %0d changes expected 0", cap_stall_err);
        else passed++;
        checks++;
        if (cap_done_pulses !== 1) $display("[TB] FAIL random_done: got %0d expected 1", cap_done_pulses);
        else passed++;
    endtask

    task automatic test_single_beat();
        bit to;
        set_cfg(16'd8, 16'd1, 16'd3, 1'b0);
        collect_frame(50, 1'b0, 16'd8, -1, to);
        checks++;
        if (to !== 1'b0 || cap_data.size() !== 1)
            $display("[TB] FAIL single_count: got timeout=%0d beats=%0d expected 0 1", to, cap_data.size());
        else passed++;
        checks++;
        if (cap_data.size() < 1) $display("[TB] FAIL single_beat: got no beat expected one");
        else if (cap_data[0] !== 64'h0706050403020100 || cap_user[0] !== 4'h3 || cap_last[0] !== 1'b1)
            $display("[TB] FAIL single_beat: got %h user %h last %b expected 0706050403020100 user 3 last 1",
                     cap_data[0], cap_user[0], cap_last[0]);
        else passed++;
        checks++;
        if (cap_done_pulses !== 1) $display("[TB] FAIL single_done: got %0d expected 1", cap_done_pulses);
        else passed++;
    endtask

    task automatic test_empty();
        bit to;
        set_cfg(16'd7, 16'd5, 16'd0, 1'b0);
        collect_frame(50, 1'b0, 16'd7, -1, to);
        checks++;
        if (to !== 1'b0 || cap_data.size() !== 0 || cap_done_pulses !== 1 || cap_done_cycle !== 1)
            $display("[TB] FAIL empty_x: got timeout=%0d beats=%0d pulses=%0d at %0d expected 0 0 1 at 1",
                     to, cap_data.size(), cap_done_pulses, cap_done_cycle);
        else passed++;
        checks++;
        if (cap_busy_at1 !== 1'b0) $display("[TB] FAIL empty_busy: got %b expected 0", cap_busy_at1);
        else passed++;
        set_cfg(16'd256, 16'd0, 16'd0, 1'b0);
        collect_frame(50, 1'b0, 16'd256, -1, to);
        checks++;
        if (to !== 1'b0 || cap_data.size() !== 0 || cap_done_pulses !== 1 || cap_done_cycle !== 1)
            $display("[TB] FAIL empty_y: got timeout=%0d beats=%0d pulses=%0d at %0d expected 0 0 1 at 1",
                     to, cap_data.size(), cap_done_pulses, cap_done_cycle);
        else passed++;
    endtask

    task automatic test_gap();
        bit to;
        int errs;
        set_cfg(16'd64, 16'd3, 16'd5, 1'b1);
        collect_frame(200, 1'b0, 16'd64, -1, to);
        errs = stream_errors(8, 3, 1'b1);
        checks++;
        if (to !== 1'b0 || errs !== 0)
            $display("[TB] FAIL gap_stream: got timeout=%0d errors=%0d expected 0 0", to, errs);
        else passed++;
        checks++;
        if (cap_idle.size() !== 2) $display("[TB] FAIL gap_runs: got %0d expected 2", cap_idle.size());
        else if (cap_idle[0] !== 5 || cap_idle[1] !== 5)
            $display("[TB] FAIL gap_length: got %0d %0d expected 5 5", cap_idle[0], cap_idle[1]);
        else passed++;
        checks++;
        if (cap_done_cycle !== cap_last_xfer + 1)
            $display("[TB] FAIL gap_tail: got done at %0d expected %0d", cap_done_cycle, cap_last_xfer + 1);
        else passed++;
        checks++;
        if (cap_data.size() < 17) $display("[TB] FAIL gap_row2: got %0d beats expected 24", cap_data.size());
        else if (cap_data[16] !== 64'h0908070605040302)
            $display("[TB] FAIL gap_row2: got %h expected 0908070605040302", cap_data[16]);
        else passed++;
    endtask

    task automatic test_restart_ignored();
        bit to;
        int errs;
        set_cfg(16'd256, 16'd2, 16'd2, 1'b0);
        collect_frame(300, 1'b0, 16'd64, 20, to);
        errs = stream_errors(32, 2, 1'b0);
        checks++;
        if (to !== 1'b0 || errs !== 0)
            $display("[TB] FAIL restart_stream: got timeout=%0d errors=%0d beats=%0d expected 0 0 64", to, errs, cap_data.size());
        else passed++;
        checks++;
        if (cap_done_pulses !== 1) $display("[TB] FAIL restart_done: got %0d expected 1", cap_done_pulses);
        else passed++;
    endtask

    task automatic test_reset_mid_frame();
        bit          hit;
        bit          to;
        int          xfers;
        int          errs;
        logic [63:0] got;
        set_cfg(16'd256, 16'd4, 16'd0, 1'b1);
        axis_if.tready = 1'b1;
        hit   = 0;
        xfers = 0;
        got   = '0;
        @(negedge aclk);
        aclk_start = 1'b1;
        @(negedge aclk);
        aclk_start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (axis_if.tvalid === 1'b1) begin
                if (xfers == 42) begin
                    hit        = 1;
                    got        = axis_if.tdata;
                    aclk_reset = 1'b1;
                    break;
                end
                xfers++;
            end
            @(negedge aclk);
        end
        checks++;
        if (hit !== 1'b1 || got !== 64'h5857565554535251)
            $display("[TB] FAIL midreset_beat: got reached=%0d data %h expected 1 5857565554535251", hit, got);
        else passed++;
        @(negedge aclk);
        checks++;
        if ({axis_if.tvalid, axis_if.tlast, aclk_busy, aclk_frame_done} !== 4'b0000 ||
            axis_if.tdata !== 64'd0 || axis_if.tuser !== 4'd0)
            $display("[TB] FAIL midreset_outputs: got flags %b data %h user %h expected all 0",
                     {axis_if.tvalid, axis_if.tlast, aclk_busy, aclk_frame_done}, axis_if.tdata, axis_if.tuser);
        else passed++;
        aclk_reset = 1'b0;
        collect_frame(400, 1'b0, 16'd256, -1, to);
        errs = stream_errors(32, 4, 1'b1);
        checks++;
        if (to !== 1'b0 || errs !== 0 || cap_done_pulses !== 1)
            $display("[TB] FAIL midreset_fresh: got timeout=%0d errors=%0d pulses=%0d expected 0 0 1", to, errs, cap_done_pulses);
        else passed++;
    endtask

    initial begin
        aclk_reset     = 1'b1;
        aclk_start     = 1'b0;
        axis_if.tready = 1'b1;
        set_cfg(16'd0, 16'd0, 16'd0, 1'b0);
        test_reset();
        test_basic_frame();
        test_random_ready();
        test_single_beat();
        test_empty();
        test_gap();
        test_restart_ignored();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
